// File: rtl/xs3_seq_conv.sv
// Sequential BCD <-> excess-3 word converter: latches a word, converts one
// 4-bit digit per cycle LSD first, then holds the result until the sink takes it.
module xs3_seq_conv #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [4*NDIGITS-1:0]   din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   dout,
    output logic [NDIGITS-1:0]     err,
    output logic                   busy
);

    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   mode_q;
    logic [4*NDIGITS-1:0]   din_q;
    logic [4*NDIGITS-1:0]   dout_q;
    logic [NDIGITS-1:0]     err_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [3:0]             cur_digit;
    logic [3:0]             digit_d;
    logic                   digit_err_d;
    logic                   accept;

    assign accept = in_valid && in_ready_q;

    // Select the digit addressed by the counter from the latched word.
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                cur_digit = din_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        digit_d     = 4'hF;
        digit_err_d = 1'b1;
        if (!mode_q) begin
            if (cur_digit <= 4'd9) begin
                digit_d     = cur_digit + 4'd3;
                digit_err_d = 1'b0;
            end
        end else begin
            if (cur_digit >= 4'd3 && cur_digit <= 4'd12) begin
                digit_d     = cur_digit - 4'd3;
                digit_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            din_q       <= '0;
            dout_q      <= '0;
            err_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= CONV;
                        din_q       <= din;
                        mode_q      <= mode;
                        cnt_q       <= '0;
                        dout_q      <= '0;
                        err_q       <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                CONV: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            dout_q[4*i +: 4] <= digit_d;
                            err_q[i]         <= digit_err_d;
                        end
                    end
                    // Counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dout      = dout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_xs3_seq_conv.sv
// Directed bench for xs3_seq_conv (NDIGITS=4). Inputs are driven and outputs
// sampled on the falling edge; valid/ready transfer happens on a rising edge when both are high.
module tb_xs3_seq_conv;

    localparam int ND = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            mode;
    logic [4*ND-1:0] din;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] dout;
    logic [ND-1:0]   err;
    logic            busy;

    int n_checks;
    int n_fail;

    logic [4*ND-1:0] r_dout;
    logic [ND-1:0]   r_err;
    int              r_lat;

    logic [15:0] exp_q[$];

    xs3_seq_conv #(.NDIGITS(ND)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .din      (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .err      (err),
        .busy     (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: callers enter and leave on a falling edge.
    task automatic run_word(input logic m, input logic [15:0] w);
        in_valid = 1'b1;
        mode     = m;
        din      = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        din      = 16'hFFFF;
        r_lat    = 0;
        while (out_valid !== 1'b1 && r_lat < 20) begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
        end
        if (out_valid !== 1'b1) r_lat = -1;
        r_dout = dout;
        r_err  = err;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mode = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, in_ready, dout, err} !== {1'b0, 1'b0, 1'b1, 16'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state: ov/busy/rdy/dout/err got %b%b%b %h %b want 001 0000 0000",
                     out_valid, busy, in_ready, dout, err);
        end
        // Accept in the very first cycle with reset low.
        rst = 1'b0;
        in_valid = 1'b1;
        din = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_accept: busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
        end
        while (out_valid !== 1'b1 && n_checks < 1000) @(negedge clk);
        take_result();
    endtask

    task automatic test_vectors();
        logic        m [4];
        logic [15:0] vin [4];
        logic [15:0] vout [4];
        logic [3:0]  verr [4];
        m[0] = 1'b0; vin[0] = 16'h1995; vout[0] = 16'h4CC8; verr[0] = 4'b0000;
        m[1] = 1'b1; vin[1] = 16'h4CC8; vout[1] = 16'h1995; verr[1] = 4'b0000;
        m[2] = 1'b0; vin[2] = 16'h12A4; vout[2] = 16'h45F7; verr[2] = 4'b0010;
        m[3] = 1'b1; vin[3] = 16'h0D53; vout[3] = 16'hFF20; verr[3] = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            run_word(m[k], vin[k]);
            n_checks++;
            if (r_lat !== 4) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d edges want 4", k, r_lat);
            end
            n_checks++;
            if (r_dout !== vout[k] || r_err !== verr[k]) begin
                n_fail++;
                $display("FAIL vec%0d_result: dout=%h err=%b want dout=%h err=%b",
                         k, r_dout, r_err, vout[k], verr[k]);
            end
            take_result();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_release: ov=%b rdy=%b busy=%b want 0 1 0",
                         k, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_stall();
        run_word(1'b0, 16'h1995);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            din      = 16'h7777;
            mode     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== 16'h4CC8 || err !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: ov=%b rdy=%b dout=%h err=%b want 1 0 4cc8 0000",
                         k, out_valid, in_ready, dout, err);
            end
        end
        in_valid = 1'b0;
        take_result();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        mode = 1'b0;
        din = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || dout !== 16'h0 || err !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: ov=%b dout=%h err=%b busy=%b rdy=%b want 0 0000 0000 0 1",
                     out_valid, dout, err, busy, in_ready);
        end
        // Stay idle a few cycles: the aborted word must not resurface.
        repeat (6) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: ov=%b busy=%b want 0 0", out_valid, busy);
        end
        run_word(1'b0, 16'h0000);
        n_checks++;
        if (r_lat !== 4 || r_dout !== 16'h3333 || r_err !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_next: lat=%0d dout=%h err=%b want 4 3333 0000", r_lat, r_dout, r_err);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [15:0] xs3 [3];
        int          w;
        int          last_acc;
        int          n_out;
        logic [15:0] e;
        words[0] = 16'h0123; xs3[0] = 16'h3456;
        words[1] = 16'h4567; xs3[1] = 16'h789A;
        words[2] = 16'h8999; xs3[2] = 16'hBCCC;
        w = 0;
        last_acc = -1;
        n_out = 0;
        mode = 1'b0;
        din = words[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (w < 3) din = words[w];
            else in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                n_out++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                n_checks++;
                if (dout !== e || err !== 4'h0) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: dout=%h err=%b want %h 0000", n_out, dout, err, e);
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != 6) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                exp_q.push_back(xs3[w]);
                w++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++;
        if (n_out != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, %0d pending want 3, 0", n_out, exp_q.size());
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] bcd;
        logic [15:0] xs;
        int          bad;
        int          v;
        bad = 0;
        for (int n = 0; n < 10000; n += 37) begin
            v = n;
            for (int d = 0; d < 4; d++) begin
                bcd[4*d +: 4] = 4'(v % 10);
                xs[4*d +: 4]  = 4'(v % 10 + 3);
                v = v / 10;
            end
            run_word(1'b0, bcd);
            take_result();
            n_checks++;
            if (r_dout !== xs || r_err !== 4'h0) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL rt_fwd %h: got %h err=%b want %h", bcd, r_dout, r_err, xs);
            end
            run_word(1'b1, r_dout);
            take_result();
            n_checks++;
            if (r_dout !== bcd || r_err !== 4'h0) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL rt_back %h: got %h err=%b want %h", xs, r_dout, r_err, bcd);
            end
        end
        // Top of range.
        run_word(1'b0, 16'h9999);
        take_result();
        n_checks++;
        if (r_dout !== 16'hCCCC || r_err !== 4'h0) begin
            n_fail++;
            $display("FAIL rt_9999: got %h err=%b want cccc 0000", r_dout, r_err);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mode = 1'b0;
        din = '0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xs3_seq_conv.md
XS3_SEQ_CONV -- requirements
Module: xs3_seq_conv

Interface
REQ-001 The module SHALL have parameter NDIGITS, default 4, number of 4-bit digits per word (legal range 1..16).
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid  input  1  source presents a word on din and mode.
REQ-005 The module SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-006 The module SHALL have port mode  input  1  0 = BCD->XS3, 1 = XS3->BCD; sampled only on accept.
REQ-007 The module SHALL have port din  input  4*NDIGITS  input word, digit i in bits [4i+3:4i].
REQ-008 The module SHALL have port out_valid  output  1  dout and err hold a converted word.
REQ-009 The module SHALL have port out_ready  input  1  sink takes the result this cycle.
REQ-010 The module SHALL have port dout  output  4*NDIGITS  converted word, same digit layout as din.
REQ-011 The module SHALL have port err  output  NDIGITS  per-digit invalid-code flag, bit i for digit i.
REQ-012 The module SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, CONV, DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; accept = in_valid && in_ready.
REQ-015 On accept the block SHALL latch din, mode, clear digit counter to 0, clear err and dout, and enter CONV.
REQ-016 In CONV the block SHALL convert one digit per cycle, least-significant digit first, writing result digit and err bit at the counter's index, then increment the counter.
REQ-017 After processing digit NDIGITS-1 the block SHALL enter DONE; out_valid SHALL rise on the NDIGITS-th edge after the accept edge.
REQ-018 Mode 0: digit d in 0..9 SHALL map to d+3 (4-bit); d in 10..15 SHALL output 4'hF with err bit set.
REQ-019 Mode 1: digit d in 3..12 SHALL map to d-3; d in 0..2 or 13..15 SHALL output 4'hF with err bit set.
REQ-020 In DONE, out_valid SHALL be 1 and dout/err SHALL stay constant until out_ready is sampled high.
REQ-021 When out_valid && out_ready, the block SHALL return to IDLE on that edge; a new word can be accepted no earlier than the following cycle (throughput one word per NDIGITS+2 cycles).
REQ-022 in_valid, din and mode changes while not IDLE SHALL have no effect.
REQ-023 Digit counter width SHALL be clog2(NDIGITS) with minimum 1 bit; no wrap beyond NDIGITS-1.

Reset
REQ-024 When rst is high at a rising edge, the block SHALL enter IDLE with dout=0, err=0, out_valid=0, busy=0, counter=0, in_ready=1 after that edge.
REQ-025 rst SHALL take priority over accept and handshake; a conversion in progress or a pending result in DONE SHALL be discarded.
REQ-026 First accept after reset release SHALL be possible in the first cycle with rst low.

Verification (NDIGITS=4)
REQ-027 Mode 0, din=16'h1995 accepted -> out_valid after 4 edges, dout=16'h4CC8, err=4'b0000.
REQ-028 Mode 1, din=16'h4CC8 accepted -> dout=16'h1995, err=4'b0000; round-trip of all BCD words 0000..9999 SHALL match.
REQ-029 Mode 0, din=16'h12A4 -> dout=16'h45F7, err=4'b0010; mode 1, din=16'h0D53 -> dout=16'hFF20, err=4'b1100.
REQ-030 out_ready held low 5 cycles in DONE -> dout, err, out_valid stable all 5 cycles; in_ready stays 0; in_valid pulses ignored.
REQ-031 rst asserted on 2nd CONV cycle -> next cycle IDLE, out_valid=0, dout=0; subsequent word 16'h0000 mode 0 yields 16'h3333.
REQ-032 Back-to-back words with in_valid and out_ready held high -> accepts spaced exactly 6 cycles apart, results in order.
